// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus bundle.
// Groups the PC/next-PC path, redirect inputs, decode handshake and imem port
// of pc_fetch_unit.
//   master: the fetch unit (drives pc_out, imem_req, instr_out, instr_valid,
//           misalign, retire_count).
//   slave : the surrounding core (AddFour, branch/jump logic, decode, imem).
interface pc_fetch_unit_if;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_in;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        stall;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        misalign;
  logic [31:0] retire_count;

  modport master (
    output pc_out, imem_req, instr_out, instr_valid, misalign, retire_count,
    input  pc_plus4_in, branch_taken, branch_target, jump, jump_target, stall,
           imem_ready, imem_data
  );

  modport slave (
    input  pc_out, imem_req, instr_out, instr_valid, misalign, retire_count,
    output pc_plus4_in, branch_taken, branch_target, jump, jump_target, stall,
           imem_ready, imem_data
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer for the single-cycle MIPS core.
// Holds the PC, fetches one instruction at a time, holds it for decode under a
// stall handshake, selects the next PC (jump > branch > PC+4) at handoff and
// counts handed-off instructions.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - pc_fetch_unit_if.master (PC, redirects, stall, imem, decode outputs)
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_fetch_unit_if.master  bus
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] count_q, count_d;

  logic        handoff;
  logic        redirect;
  logic [31:0] raw_target;

  // Redirect inputs only matter on the handoff cycle; nothing is latched.
  assign handoff  = (state_q == S_VALID) && !bus.stall;
  assign redirect = bus.jump || bus.branch_taken;

  always_comb begin
    if (bus.jump) begin
      raw_target = bus.jump_target;
    end else if (bus.branch_taken) begin
      raw_target = bus.branch_target;
    end else begin
      raw_target = bus.pc_plus4_in;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    misalign_d = 1'b0;
    count_d    = count_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.imem_ready) begin
          instr_d = bus.imem_data;
          valid_d = 1'b1;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (handoff) begin
          // Force word alignment; flag only redirect targets with low bits set.
          pc_d       = {raw_target[31:2], 2'b00};
          misalign_d = redirect && (raw_target[1:0] != 2'b00);
          count_d    = count_q + 32'd1;
          valid_d    = 1'b0;
          state_d    = S_FETCH;
        end
      end
      default: begin
        state_d = S_BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign bus.pc_out       = pc_q;
  assign bus.imem_req     = (state_q == S_FETCH);
  assign bus.instr_out    = instr_q;
  assign bus.instr_valid  = valid_q;
  assign bus.misalign     = misalign_q;
  assign bus.retire_count = count_q;

endmodule
